// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : keypad_scan_ctrl
// 4x4 keypad column scanner with press/release debounce and a valid/ack key port.
// Rev    : 1.0
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_overrun
);

  localparam logic [7:0] C_DWELL_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] C_DEB_TARGET = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_row_meta, r_row_s;
  logic [7:0] r_dwell;
  logic [1:0] r_col_idx, w_col_idx_nxt;
  logic [1:0] r_row_idx, w_row_idx_nxt, w_row_lowest;
  logic [3:0] r_deb_cnt, w_deb_cnt_nxt, w_deb_inc;
  logic [3:0] r_column;
  logic [3:0] r_key_code;
  logic       r_key_valid, r_key_overrun;
  logic       w_sample, w_qualify, w_row_hit, w_accept;
  logic [3:0] w_qual_code;

  assign w_sample    = (r_dwell == C_DWELL_LAST);
  assign w_row_hit   = r_row_s[r_row_idx];
  assign w_deb_inc   = r_deb_cnt + 4'd1;
  assign w_accept    = r_key_valid & key_ack;
  assign w_qual_code = {w_row_idx_nxt, r_col_idx};

  // Row 0 wins when several rows are active on the driven column.
  always_comb begin
    w_row_lowest = 2'd0;
    if (r_row_s[0])      w_row_lowest = 2'd0;
    else if (r_row_s[1]) w_row_lowest = 2'd1;
    else if (r_row_s[2]) w_row_lowest = 2'd2;
    else if (r_row_s[3]) w_row_lowest = 2'd3;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_col_idx_nxt = r_col_idx;
    w_row_idx_nxt = r_row_idx;
    w_deb_cnt_nxt = r_deb_cnt;
    w_qualify     = 1'b0;
    if (w_sample) begin
      case (r_state)
        ST_SCAN: begin
          if (r_row_s == 4'd0) begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end else begin
            w_row_idx_nxt = w_row_lowest;
            if (DEBOUNCE == 1) begin
              w_qualify     = 1'b1;
              w_state_nxt   = ST_RELEASE;
              w_deb_cnt_nxt = 4'd0;
            end else begin
              w_state_nxt   = ST_PRESS;
              w_deb_cnt_nxt = 4'd1;
            end
          end
        end
        ST_PRESS: begin
          if (w_row_hit) begin
            if (w_deb_inc == C_DEB_TARGET) begin
              w_qualify     = 1'b1;
              w_state_nxt   = ST_RELEASE;
              w_deb_cnt_nxt = 4'd0;
            end else begin
              w_deb_cnt_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt   = ST_SCAN;
            w_col_idx_nxt = r_col_idx + 2'd1;
            w_deb_cnt_nxt = 4'd0;
          end
        end
        ST_RELEASE: begin
          // Only the captured row matters; other keys are ignored until release.
          if (!w_row_hit) begin
            if (w_deb_inc == C_DEB_TARGET) begin
              w_state_nxt   = ST_SCAN;
              w_col_idx_nxt = r_col_idx + 2'd1;
              w_deb_cnt_nxt = 4'd0;
            end else begin
              w_deb_cnt_nxt = w_deb_inc;
            end
          end else begin
            w_deb_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt   = ST_SCAN;
          w_deb_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SCAN;
      r_row_meta <= 4'd0;
      r_row_s    <= 4'd0;
      r_dwell    <= 8'd0;
      r_col_idx  <= 2'd0;
      r_row_idx  <= 2'd0;
      r_deb_cnt  <= 4'd0;
      r_column   <= 4'b0001;
    end else begin
      r_state    <= w_state_nxt;
      r_row_meta <= row;
      r_row_s    <= r_row_meta;
      r_dwell    <= w_sample ? 8'd0 : r_dwell + 8'd1;
      r_col_idx  <= w_col_idx_nxt;
      r_row_idx  <= w_row_idx_nxt;
      r_deb_cnt  <= w_deb_cnt_nxt;
      r_column   <= 4'b0001 << w_col_idx_nxt;
    end
  end

  // An ack landing on the qualification cycle frees the slot for the new key.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code    <= 4'd0;
      r_key_valid   <= 1'b0;
      r_key_overrun <= 1'b0;
    end else begin
      if (w_qualify && (!r_key_valid || key_ack)) begin
        r_key_code  <= w_qual_code;
        r_key_valid <= 1'b1;
      end else if (w_accept) begin
        r_key_valid <= 1'b0;
      end
      if (w_qualify && r_key_valid && !key_ack) begin
        r_key_overrun <= 1'b1;
      end else if (w_accept) begin
        r_key_overrun <= 1'b0;
      end
    end
  end

  assign column      = r_column;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_overrun = r_key_overrun;

endmodule
`default_nettype wire
